// File: rtl/score_ascii_writer.sv
// rtl/score_ascii_writer.sv - sequential binary-to-two-digit ASCII converter (repeated subtract-10).
// Optional macro SCORE_BLANK_LEADING_ZERO_EN: a zero tens digit is shown as a space.
module score_ascii_writer #(
    parameter int VALUE_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic [15:0]        text_out
);

    typedef enum logic {
        ST_IDLE,
        ST_DIV
    } state_t;

`ifdef SCORE_BLANK_LEADING_ZERO_EN
    localparam logic [15:0] TEXT_RST = 16'h2030;
`else
    localparam logic [15:0] TEXT_RST = 16'h3030;
`endif

    localparam logic [VALUE_W-1:0] TEN     = VALUE_W'(10);
    localparam logic [VALUE_W-1:0] MAX_VAL = VALUE_W'(99);

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] rem_q, rem_d;
    logic [3:0]         tens_q, tens_d;
    logic [15:0]        text_q, text_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         tens_char;
    logic [7:0]         unit_char;

    always_comb begin
        unit_char = 8'h30 + 8'(rem_q);
`ifdef SCORE_BLANK_LEADING_ZERO_EN
        tens_char = (tens_q == 4'd0) ? 8'h20 : (8'h30 + {4'h0, tens_q});
`else
        tens_char = 8'h30 + {4'h0, tens_q};
`endif
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tens_d  = tens_q;
        text_d  = text_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Clamp in full input width so values above 99 never alias.
                    rem_d   = (32'(value) > 32'd99) ? MAX_VAL : value;
                    tens_d  = 4'd0;
                    state_d = ST_DIV;
                    busy_d  = 1'b1;
                end
            end
            ST_DIV: begin
                if (rem_q >= TEN) begin
                    rem_d  = rem_q - TEN;
                    tens_d = tens_q + 4'd1;
                end else begin
                    text_d  = {tens_char, unit_char};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            tens_q  <= 4'd0;
            text_q  <= TEXT_RST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tens_q  <= tens_d;
            text_q  <= text_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign text_out = text_q;

endmodule

// File: tb/tb_score_ascii_writer.sv
// tb/tb_score_ascii_writer.sv - directed bench with cycle-level reference model for score_ascii_writer.
module tb_score_ascii_writer;

    localparam int VW = 7;

`ifdef SCORE_BLANK_LEADING_ZERO_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [VW-1:0] value = '0;
    logic          busy;
    logic          done;
    logic [15:0]   text_out;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    score_ascii_writer #(.VALUE_W(VW)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy), .done(done), .text_out(text_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ascii_of(input int v);
        int c, t, u;
        logic [7:0] hi, lo;
        c  = (v > 99) ? 99 : v;
        t  = c / 10;
        u  = c % 10;
        hi = (BLANK && t == 0) ? 8'h20 : 8'(8'h30 + t);
        lo = 8'(8'h30 + u);
        return {hi, lo};
    endfunction

    function automatic logic [15:0] rst_text();
        return BLANK ? 16'h2030 : 16'h3030;
    endfunction

    // Reference model: an accepted request completes a fixed number of edges later.
    int          edge_cnt = 0;
    bit          m_pending = 1'b0;
    int          m_done_edge = 0;
    logic [15:0] m_exp = 16'h0;
    logic [15:0] m_text = 16'h0;
    bit          m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending = 1'b0;
            m_done    = 1'b0;
            m_text    = rst_text();
        end else begin
            edge_cnt = edge_cnt + 1;
            m_done   = 1'b0;
            if (!m_pending) begin
                if (start) begin
                    m_pending   = 1'b1;
                    m_exp       = ascii_of(int'(value));
                    m_done_edge = edge_cnt + (((int'(value) > 99) ? 99 : int'(value)) / 10) + 1;
                end
            end else if (edge_cnt == m_done_edge) begin
                m_pending = 1'b0;
                m_text    = m_exp;
                m_done    = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", 32'(busy), 32'(m_pending));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_text", 32'(text_out), 32'(m_text));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one conversion, then measure edges until done.
    task automatic convert(input int v, input logic [15:0] exp_text, input int exp_lat);
        int n;
        start = 1'b1;
        value = VW'(v);
        tick();
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (n < 20) begin
            tick();
            n = n + 1;
            if (done) break;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        chk("text_literal", 32'(text_out), 32'(exp_text));
        chk("model_text_literal", 32'(m_text), 32'(exp_text));
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 20) begin
            tick();
            n = n + 1;
            if (done) break;
        end
    endtask

    initial begin
        int n;
        #2 rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_text", 32'(text_out), 32'(rst_text()));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        convert(47, 16'h3437, 5);
        convert(5, BLANK ? 16'h2035 : 16'h3035, 1);
        convert(120, 16'h3939, 10);
        convert(0, BLANK ? 16'h2030 : 16'h3030, 1);
        convert(10, 16'h3130, 2);
        convert(9, BLANK ? 16'h2039 : 16'h3039, 1);

        // Start while busy is ignored.
        start = 1'b1;
        value = VW'(23);
        tick();
        value = VW'(88);
        tick();
        start = 1'b0;
        wait_done(n);
        chk("busy_ignore_lat", 32'(n + 1), 32'd3);
        chk("busy_ignore_text", 32'(text_out), 32'h3233);
        repeat (12) tick();
        chk("text_stable", 32'(text_out), 32'h3233);

        // Start held high: back-to-back conversions.
        start = 1'b1;
        value = VW'(99);
        tick();
        wait_done(n);
        chk("b2b_first_lat", 32'(n), 32'd10);
        chk("b2b_first_text", 32'(text_out), 32'h3939);
        value = VW'(10);
        wait_done(n);
        chk("b2b_second_lat", 32'(n), 32'd3);
        chk("b2b_second_text", 32'(text_out), 32'h3130);
        start = 1'b0;
        tick();
        tick();
        chk("b2b_idle", 32'(busy), 32'd0);

        // Reset mid-conversion.
        start = 1'b1;
        value = VW'(99);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_text", 32'(text_out), 32'(rst_text()));
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        n = 0;
        repeat (15) begin
            tick();
            if (done) n = n + 1;
        end
        chk("midrst_no_done", 32'(n), 32'd0);
        chk("midrst_text_after", 32'(text_out), 32'(rst_text()));

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/score_ascii_writer.md
Name: score_ascii_writer

Overview:
- Converts a binary score/counter value into two ASCII decimal characters.
- Produces the 16-bit text word consumed by the two-character text RAM feeding the on-screen text renderer: [15:8] is the first (tens) character, [7:0] is the second (units) character.
- Conversion is sequential: it repeatedly subtracts 10 and uses a start/busy/done handshake, so game logic can request an update at any time and later latch a stable word.

Parameters:
- VALUE_W, 7, width of the binary input value; legal range 4..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  conversion request; sampled only while idle.
- value  input  VALUE_W  unsigned binary value to convert; captured on start acceptance.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when text_out has just been updated.
- text_out  output  16  [15:8] tens ASCII, [7:0] units ASCII; holds its value between conversions.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0; done=0.
  - text_out=16'h3030 ("00"); 16'h2030 when the optional feature is compiled in.
  - Internal remainder and tens counter are cleared.
- State IDLE:
  - busy=0.
  - start=1 at a rising edge: remainder <= min(value, 99), tens <= 0, state <= DIV. This is the acceptance edge (edge 0).
- State DIV:
  - busy=1. One operation per clock.
  - If remainder >= 10: remainder -= 10, tens += 1, stay in DIV.
  - Else: text_out <= {8'h30+tens, 8'h30+remainder}, done <= 1, state <= IDLE.
- done: high exactly one cycle; deasserted on the next edge unconditionally.
- Latency: done is high in the cycle after edge tens+1, where tens = min(value,99)/10.
  - value 0..9 -> done 1 cycle after acceptance.
  - value 99 -> done 10 cycles after acceptance (worst case).
- Saturation:
  - value > 99 -> treated as 99; output "99".
  - Compare in VALUE_W bits before clamping; no truncation artefacts.
- start while busy: ignored; no queuing; value changes during DIV have no effect.
- start held high continuously: a new conversion is accepted in the cycle done is high (state already IDLE). Back-to-back period = latency + 1 cycles.
- text_out changes only on the DIV-exit edge; it never shows partial values.
- Reset mid-conversion: immediate return to reset values; the pending conversion is lost and done does not pulse.
- tens counter: 4 bits; max 9 by construction. Remainder: VALUE_W bits.

Optional Feature:
- Macro: SCORE_BLANK_LEADING_ZERO_EN.
- Defined: when tens==0 the first character is 8'h20 (space) instead of 8'h30; reset value 16'h2030. Latency is unchanged.
- Undefined: the tens character is always 8'h30+tens; reset value 16'h3030.

Test Plan:
- Reset asserted mid-run, then released -> text_out=16'h3030, busy=0, done=0; with the macro defined, 16'h2030.
- start with value=47 -> busy high from the edge after acceptance; done pulses 5 cycles after acceptance; text_out=16'h3437 ("47").
- start with value=5, macro undefined/defined -> text_out=16'h3035 / 16'h2035; done 1 cycle after acceptance.
- start with value=120 (VALUE_W=7) -> text_out=16'h3939; done 10 cycles after acceptance.
- value=23 accepted, then start=1 with value=88 while busy -> 88 ignored; done once with "23" (16'h3233); text_out stable until a new start.
- start held high, value switching 99 then 10 -> first done with "99"; second conversion accepted in the done cycle; second done 2 cycles later with 16'h3130.
